// File: rtl/rr_arb8_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// The arbiter takes the slave side; the master side drives req and observes the grant.
interface rr_arb8_if #(
    parameter int NREQ = 8
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [3:0]      gnt_code;
    logic            busy;
    logic            timeout;

    modport master (
        output req,
        input  gnt,
        input  gnt_code,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_code,
        output busy,
        output timeout
    );
endinterface

// File: rtl/rr_arb8.sv
// Round-robin arbiter for 8 requesters in front of a shared datapath.
// The owner keeps the resource while it requests, up to MAX_HOLD cycles, then one turnaround cycle.
module rr_arb8 #(
    parameter int NREQ     = 8,
    parameter int MAX_HOLD = 16,
    parameter int CW       = 5
) (
    input  logic       clk,
    input  logic       rst,
    rr_arb8_if.slave   bus
);
    localparam logic [1:0]    S_IDLE   = 2'd0;
    localparam logic [1:0]    S_GRANT  = 2'd1;
    localparam logic [1:0]    S_GAP    = 2'd2;
    localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD);
    localparam bit            HOLD_EN  = (MAX_HOLD != 0);

    logic [1:0]      r_state;
    logic [2:0]      r_ptr;
    logic [2:0]      r_owner;
    logic [CW-1:0]   r_cnt;
    logic [NREQ-1:0] r_gnt;
    logic [3:0]      r_code;
    logic            r_busy;
    logic            r_timeout;

    logic [2:0]      w_win;
    logic            w_any;
    logic [CW-1:0]   w_cnt_inc;

    // Scan from the highest offset down so the lowest offset from r_ptr wins.
    always_comb begin
        w_win = r_ptr;
        w_any = |bus.req;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req[r_ptr + 3'(k)]) w_win = r_ptr + 3'(k);
        end
    end

    // Without a hold limit the counter must not wrap back to a small value.
    always_comb begin
        w_cnt_inc = r_cnt + CW'(1);
        if (!HOLD_EN && (r_cnt == '1)) w_cnt_inc = r_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= 3'd0;
            r_owner   <= 3'd0;
            r_cnt     <= '0;
            r_gnt     <= '0;
            r_code    <= 4'b0000;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt   <= NREQ'(1) << w_win;
                        r_code  <= {1'b1, w_win};
                        r_busy  <= 1'b1;
                        r_owner <= w_win;
                        r_ptr   <= w_win + 3'd1;
                        r_cnt   <= CW'(1);
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (!bus.req[r_owner]) begin
                        r_gnt   <= '0;
                        r_code  <= 4'b0000;
                        r_busy  <= 1'b0;
                        r_state <= S_GAP;
                    end else if (HOLD_EN && (r_cnt == HOLD_LIM)) begin
                        r_gnt     <= '0;
                        r_code    <= 4'b0000;
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                        r_state   <= S_GAP;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_GAP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_gnt   <= '0;
                    r_code  <= 4'b0000;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.gnt_code = r_code;
    assign bus.busy     = r_busy;
    assign bus.timeout  = r_timeout;
endmodule

// File: tb/tb_rr_arb8.sv
// Directed bench for rr_arb8: hold timeout, rotation, wrap-around, no preemption, reset, no-timeout build.
module tb_rr_arb8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    rr_arb8_if bus  ();
    rr_arb8_if bus0 ();

    rr_arb8 #(.NREQ(8), .MAX_HOLD(16), .CW(5)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    rr_arb8 #(.NREQ(8), .MAX_HOLD(0), .CW(5)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    task automatic step;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        bus.req  = 8'h00;
        bus0.req = 8'h00;
        step;
        step;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.req  = 8'h00;
        bus0.req = 8'h00;
        step;
        step;
        n_total++; if (bus.gnt !== 8'h00) $display("FAIL reset_gnt: got %h expected %h", bus.gnt, 8'h00); else n_pass++;
        n_total++; if (bus.gnt_code !== 4'b0000) $display("FAIL reset_code: got %b expected %b", bus.gnt_code, 4'b0000); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else n_pass++;
        n_total++; if (bus.timeout !== 1'b0) $display("FAIL reset_timeout: got %b expected 0", bus.timeout); else n_pass++;
        n_total++; if (bus0.gnt !== 8'h00) $display("FAIL reset_gnt0: got %h expected %h", bus0.gnt, 8'h00); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_hold_timeout;
        int bad;
        do_reset;
        bus.req = 8'h04;
        step;
        n_total++; if (bus.gnt !== 8'h04) $display("FAIL hold_first_gnt: got %h expected %h", bus.gnt, 8'h04); else n_pass++;
        n_total++; if (bus.gnt_code !== 4'b1010) $display("FAIL hold_first_code: got %b expected %b", bus.gnt_code, 4'b1010); else n_pass++;
        n_total++; if (bus.busy !== 1'b1) $display("FAIL hold_busy: got %b expected 1", bus.busy); else n_pass++;
        bad = 0;
        repeat (15) begin
            step;
            if (bus.gnt !== 8'h04 || bus.timeout !== 1'b0) bad++;
        end
        n_total++; if (bad !== 0) $display("FAIL hold_16_cycles: got %0d bad cycles expected 0", bad); else n_pass++;
        step;
        n_total++; if (bus.timeout !== 1'b1) $display("FAIL timeout_pulse: got %b expected 1", bus.timeout); else n_pass++;
        n_total++; if (bus.gnt !== 8'h00) $display("FAIL timeout_gnt: got %h expected %h", bus.gnt, 8'h00); else n_pass++;
        step;
        n_total++; if (bus.timeout !== 1'b0) $display("FAIL timeout_one_cycle: got %b expected 0", bus.timeout); else n_pass++;
        n_total++; if (bus.gnt !== 8'h00) $display("FAIL timeout_idle_gnt: got %h expected %h", bus.gnt, 8'h00); else n_pass++;
        step;
        n_total++; if (bus.gnt_code !== 4'b1010) $display("FAIL rewin_code: got %b expected %b", bus.gnt_code, 4'b1010); else n_pass++;
        bus.req = 8'h00;
        step;
        step;
    endtask

    task automatic test_rotation;
        logic [2:0] idx;
        logic [7:0] exp_gnt;
        do_reset;
        bus.req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            idx = 3'(k);
            exp_gnt = 8'h01 << idx;
            step;
            n_total++; if (bus.gnt_code !== {1'b1, idx}) $display("FAIL rot_code[%0d]: got %b expected %b", k, bus.gnt_code, {1'b1, idx}); else n_pass++;
            n_total++; if (bus.gnt !== exp_gnt) $display("FAIL rot_gnt[%0d]: got %h expected %h", k, bus.gnt, exp_gnt); else n_pass++;
            step;
            step;
            n_total++; if (bus.gnt !== exp_gnt) $display("FAIL rot_hold3[%0d]: got %h expected %h", k, bus.gnt, exp_gnt); else n_pass++;
            bus.req = 8'hFF & ~exp_gnt;
            step;
            n_total++; if (bus.gnt !== 8'h00) $display("FAIL rot_gap[%0d]: got %h expected %h", k, bus.gnt, 8'h00); else n_pass++;
            bus.req = 8'hFF;
            step;
            n_total++; if (bus.busy !== 1'b0) $display("FAIL rot_idle_busy[%0d]: got %b expected 0", k, bus.busy); else n_pass++;
        end
        bus.req = 8'h00;
        step;
        step;
    endtask

    task automatic test_wraparound;
        do_reset;
        bus.req = 8'h40;
        step;
        n_total++; if (bus.gnt !== 8'h40) $display("FAIL wrap_gnt6: got %h expected %h", bus.gnt, 8'h40); else n_pass++;
        bus.req = 8'h00;
        step;
        n_total++; if (bus.gnt !== 8'h00) $display("FAIL wrap_gap: got %h expected %h", bus.gnt, 8'h00); else n_pass++;
        bus.req = 8'h21;
        step;
        n_total++; if (bus.gnt !== 8'h00) $display("FAIL wrap_gap_ignores_req: got %h expected %h", bus.gnt, 8'h00); else n_pass++;
        step;
        n_total++; if (bus.gnt !== 8'h01) $display("FAIL wrap_gnt0: got %h expected %h", bus.gnt, 8'h01); else n_pass++;
        n_total++; if (bus.gnt_code !== 4'b1000) $display("FAIL wrap_code0: got %b expected %b", bus.gnt_code, 4'b1000); else n_pass++;
        bus.req = 8'h20;
        step;
        step;
        step;
        n_total++; if (bus.gnt !== 8'h20) $display("FAIL wrap_gnt5: got %h expected %h", bus.gnt, 8'h20); else n_pass++;
        n_total++; if (bus.gnt_code !== 4'b1101) $display("FAIL wrap_code5: got %b expected %b", bus.gnt_code, 4'b1101); else n_pass++;
        bus.req = 8'h00;
        step;
        step;
    endtask

    task automatic test_no_preempt;
        do_reset;
        bus.req = 8'h08;
        step;
        n_total++; if (bus.gnt_code !== 4'b1011) $display("FAIL nopre_code3: got %b expected %b", bus.gnt_code, 4'b1011); else n_pass++;
        bus.req = 8'h88;
        repeat (5) step;
        n_total++; if (bus.gnt !== 8'h08) $display("FAIL nopre_hold: got %h expected %h", bus.gnt, 8'h08); else n_pass++;
        bus.req = 8'h80;
        step;
        n_total++; if (bus.gnt !== 8'h00) $display("FAIL nopre_gap: got %h expected %h", bus.gnt, 8'h00); else n_pass++;
        step;
        n_total++; if (bus.gnt !== 8'h00) $display("FAIL nopre_idle: got %h expected %h", bus.gnt, 8'h00); else n_pass++;
        step;
        n_total++; if (bus.gnt !== 8'h80) $display("FAIL nopre_gnt7: got %h expected %h", bus.gnt, 8'h80); else n_pass++;
        n_total++; if (bus.gnt_code !== 4'b1111) $display("FAIL nopre_code7: got %b expected %b", bus.gnt_code, 4'b1111); else n_pass++;
        bus.req = 8'h00;
        step;
        step;
    endtask

    task automatic test_reset_mid;
        do_reset;
        bus.req = 8'h10;
        step;
        n_total++; if (bus.gnt !== 8'h10) $display("FAIL rstmid_pre_gnt: got %h expected %h", bus.gnt, 8'h10); else n_pass++;
        rst = 1'b1;
        step;
        n_total++; if (bus.gnt !== 8'h00) $display("FAIL rstmid_gnt: got %h expected %h", bus.gnt, 8'h00); else n_pass++;
        n_total++; if (bus.gnt_code !== 4'b0000) $display("FAIL rstmid_code: got %b expected %b", bus.gnt_code, 4'b0000); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", bus.busy); else n_pass++;
        rst = 1'b0;
        bus.req = 8'h11;
        step;
        n_total++; if (bus.gnt !== 8'h01) $display("FAIL rstmid_req11: got %h expected %h", bus.gnt, 8'h01); else n_pass++;
        // Second pass picks a request pattern where a stale pointer of 5 would pick requester 5.
        rst = 1'b1;
        bus.req = 8'h10;
        step;
        rst = 1'b0;
        step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        bus.req = 8'h30;
        step;
        n_total++; if (bus.gnt_code !== 4'b1100) $display("FAIL rstmid_ptr0: got %b expected %b", bus.gnt_code, 4'b1100); else n_pass++;
        bus.req = 8'h00;
        step;
        step;
    endtask

    task automatic test_no_timeout;
        int bad;
        int tos;
        do_reset;
        bus0.req = 8'h01;
        step;
        bad = 0;
        tos = 0;
        repeat (100) begin
            if (bus0.gnt !== 8'h01) bad++;
            if (bus0.timeout !== 1'b0) tos++;
            step;
        end
        n_total++; if (bad !== 0) $display("FAIL notmo_revoked: got %0d ungranted cycles expected 0", bad); else n_pass++;
        n_total++; if (tos !== 0) $display("FAIL notmo_pulse: got %0d timeout cycles expected 0", tos); else n_pass++;
        n_total++; if (bus0.gnt_code !== 4'b1000) $display("FAIL notmo_code: got %b expected %b", bus0.gnt_code, 4'b1000); else n_pass++;
        bus0.req = 8'h00;
        step;
        step;
    endtask

    initial begin
        bus.req  = 8'h00;
        bus0.req = 8'h00;
        test_reset;
        test_hold_timeout;
        test_rotation;
        test_wraparound;
        test_no_preempt;
        test_reset_mid;
        test_no_timeout;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
